// File: rtl/mips_hilo_div_unit.sv
// mips_hilo_div_unit: iterative signed divider that owns the HI/LO registers.
// A start in IDLE runs WIDTH restoring-division steps in CALC. It then spends one
// FIX cycle applying signs (or the divide-by-zero result) and writes HI/LO at
// the closing edge. Stall is raised for any div/mf request that arrives while
// the unit is busy.
module mips_hilo_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             div,
    input  logic [1:0]       mf,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, abs_rt, rs_raw;
    logic             sign_q, sign_r, dz;
    logic             start;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] abs_rs_in, abs_rt_in, quo_fix, rem_fix;

    // Magnitudes of the operands. The most negative value maps to itself,
    // which is correct when the result is read as unsigned.
    assign abs_rs_in = rs_data[WIDTH-1] ? (~rs_data + ONE) : rs_data;
    assign abs_rt_in = rt_data[WIDTH-1] ? (~rt_data + ONE) : rt_data;

    // One restoring step. The shifted remainder needs WIDTH+1 bits because
    // the divisor magnitude can be 2^(WIDTH-1).
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, abs_rt};

    // Sign correction applied in FIX.
    assign quo_fix = sign_q ? (~quo + ONE) : quo;
    assign rem_fix = sign_r ? (~rem + ONE) : rem;

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and control outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (div) begin
                    start     = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(1)) state_nxt = FIX;
            end
            FIX: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture and the per-cycle quotient/remainder iteration.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            abs_rt <= '0;
            rs_raw <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            dz     <= 1'b0;
        end else if (start) begin
            cnt    <= CW'(WIDTH);
            rem    <= '0;
            quo    <= abs_rs_in;
            abs_rt <= abs_rt_in;
            rs_raw <= rs_data;
            sign_q <= rs_data[WIDTH-1] ^ rt_data[WIDTH-1];
            sign_r <= rs_data[WIDTH-1];
            dz     <= (rt_data == '0);
        end else if (state == CALC) begin
            cnt <= cnt - CW'(1);
            if (!trial[WIDTH]) begin
                rem <= trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= rem_sh[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // HI/LO are written only at the edge that closes FIX.
    // Divide by zero yields all-ones / raw dividend.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hi <= '0;
            lo <= '0;
        end else if (done) begin
            lo <= dz ? '1     : quo_fix;
            hi <= dz ? rs_raw : rem_fix;
        end
    end

    assign stall   = busy & (div | mf[1]);
    assign mf_data = (mf == 2'b10) ? hi :
                     (mf == 2'b11) ? lo : '0;

endmodule

// File: tb/tb_mips_hilo_div_unit.sv
// Self-checking bench for mips_hilo_div_unit: directed literal cases plus a
// randomized run, all compared every cycle against an arithmetic reference.
module tb_mips_hilo_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         div;
    logic [1:0]   mf;
    logic [W-1:0] rs_data, rt_data;
    logic         busy, done, stall;
    logic [W-1:0] mf_data, hi, lo;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;
    int done_cyc = 0;

    mips_hilo_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_b(rst_b), .div(div), .mf(mf),
        .rs_data(rs_data), .rt_data(rt_data),
        .busy(busy), .done(done), .stall(stall),
        .mf_data(mf_data), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference divide: signed arithmetic, truncating toward zero.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb, lq, lr;
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
        end
    endfunction

    // Reference model: a pending result that lands WIDTH+1 edges after start.
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int           m_cnt = 0;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_hi  = '0;
            m_lo  = '0;
            m_cnt = 0;
        end else if (m_cnt == 0) begin
            if (div) begin
                ref_div(rs_data, rt_data, p_lo, p_hi);
                m_cnt = W + 1;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    bit run_chk = 1'b0;
    always @(negedge clk) begin
        logic         e_busy, e_done, e_stall;
        logic [W-1:0] e_mf;
        if (run_chk) begin
            e_busy  = (m_cnt > 0);
            e_done  = (m_cnt == 1);
            e_stall = e_busy & (div | mf[1]);
            e_mf    = (mf == 2'b10) ? m_hi : (mf == 2'b11) ? m_lo : '0;
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("stall", stall, e_stall);
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("mf_data", mf_data, e_mf);
        end
    end

    // Start a divide; when sync is 0 the call comes from a point just after a negedge.
    task automatic issue(input bit sync, input logic [W-1:0] a, input logic [W-1:0] b);
        if (sync) @(posedge clk);
        #1;
        div = 1'b1; rs_data = a; rt_data = b;
        @(posedge clk);
        #1;
        t0 = cyc;
        div = 1'b0; rs_data = $urandom; rt_data = $urandom;
    endtask

    task automatic wait_done(input string name, input logic [W-1:0] elo, input logic [W-1:0] ehi);
        int dk = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) begin
                dk = cyc - t0 + 1;
                done_cyc = cyc;
                break;
            end
        end
        chk({name, " done_cycle"}, dk, W + 1);
        @(negedge clk);
        chk({name, " lo"}, lo, elo);
        chk({name, " hi"}, hi, ehi);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            4: return W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k, t_first;
        rst_b = 1'b0; div = 1'b0; mf = 2'b00; rs_data = '0; rt_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        @(negedge clk);
        #1;
        rst_b = 1'b1;
        run_chk = 1'b1;

        issue(1, 32'd7, 32'd2);
        wait_done("7/2", 32'd3, 32'd1);
        #1; mf = 2'b11; #1;
        chk("7/2 mflo", mf_data, 32'd3);
        mf = 2'b00;

        // Reset in cycle 10 of a divide.
        issue(1, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst_b = 1'b0;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset hi", hi, 0);
        chk("midreset lo", lo, 0);
        @(negedge clk);
        #1;
        rst_b = 1'b1; mf = 2'b11;
        #1;
        chk("midreset mflo", mf_data, 0);
        mf = 2'b00;

        issue(1, 32'hFFFF_FFF9, 32'd2);
        wait_done("-7/2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        issue(1, 32'd7, 32'hFFFF_FFFE);
        wait_done("7/-2", 32'hFFFF_FFFD, 32'd1);
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("ovf", 32'h8000_0000, 32'd0);
        issue(1, 32'd100, 32'd0);
        wait_done("100/0", 32'hFFFF_FFFF, 32'h64);

        // MFLO arriving in cycle 5 stalls until the result is visible.
        issue(1, 32'd45, 32'd4);
        repeat (4) @(posedge clk);
        #1;
        mf = 2'b11;
        k = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 0) chk("mf stall c5", stall, 1);
            if (!stall) begin
                k = cyc - t0 + 1;
                break;
            end
        end
        chk("mf stall release cycle", k, 34);
        chk("mf new lo", mf_data, 32'd11);
        #1; mf = 2'b00;

        // A second div in cycle 20 stalls and is dropped.
        issue(1, 32'd100, 32'd7);
        repeat (19) @(posedge clk);
        #1;
        div = 1'b1; rs_data = 32'd5; rt_data = 32'd1;
        @(negedge clk);
        chk("div2 stall", stall, 1);
        @(posedge clk);
        #1;
        div = 1'b0;
        wait_done("100/7 w/ div2", 32'd14, 32'd2);

        // Back-to-back: 20/3 issued in cycle 34 of 7/2.
        issue(1, 32'd7, 32'd2);
        t_first = t0;
        wait_done("b2b 7/2", 32'd3, 32'd1);
        issue(0, 32'd20, 32'd3);
        wait_done("b2b 20/3", 32'd6, 32'd2);
        chk("b2b done abs cycle", done_cyc - t_first + 1, 67);

        // Randomized traffic.
        for (int n = 0; n < 5000; n++) begin
            @(posedge clk);
            #1;
            div     = ($urandom_range(0, 7) == 0);
            mf      = 2'($urandom_range(0, 3));
            rs_data = pick();
            rt_data = pick();
        end
        #1;
        div = 1'b0; mf = 2'b00;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
